// File: rtl/frame_loader_bram0.sv
// frame_loader_bram0: stores one video frame of IMAGE_WIDTH x IMAGE_HEIGHT pixels
// into BRAM0 through a registered write port.
//
// Ports:
//   clk, rst_n           - clock (rising edge), synchronous active-low reset
//   i_start              - arm the loader for one frame (honoured in IDLE only)
//   i_valid / o_ready    - pixel beat handshake
//   i_data, i_sof, i_eol - pixel value, first-pixel-of-frame, last-pixel-of-line
//   b0_d0/ce0/we0/addr0  - BRAM0 write port, one cycle after the accepted beat
//   o_complete           - one-cycle pulse with the final write strobe
//   o_num_cnt            - pixel count of the last stored frame
//   o_err                - sticky framing error (cleared by the next accepted i_start)
//   o_state              - FSM state: 00 IDLE, 01 WAIT_SOF, 10 LOAD, 11 DONE
module frame_loader_bram0 #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 279,
  parameter int unsigned IMAGE_HEIGHT = 210
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sof,
  input  logic                  i_eol,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic                  o_complete,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_err,
  output logic [1:0]            o_state
);

  localparam int unsigned ImageSize = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned ColW      = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned RowW      = $clog2(IMAGE_HEIGHT + 1);

  localparam logic [ADDR_WIDTH-1:0] LastPix   = ADDR_WIDTH'(ImageSize - 1);
  localparam logic [ADDR_WIDTH-1:0] FrameSize = ADDR_WIDTH'(ImageSize);
  localparam logic [ColW-1:0]       LastCol   = ColW'(IMAGE_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWaitSof = 2'b01,
    StLoad    = 2'b10,
    StDone    = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Position of the beat being written; forced to the frame origin on a start-of-frame beat.
  logic                  do_wr;
  logic [ADDR_WIDTH-1:0] wr_pix;
  logic [ColW-1:0]       wr_col;
  logic [RowW-1:0]       wr_row;
  logic                  accept;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    num_d   = num_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    do_wr   = 1'b0;
    wr_pix  = pix_q;
    wr_col  = col_q;
    wr_row  = row_q;

    o_ready = (state_q == StWaitSof) || (state_q == StLoad);
    accept  = i_valid && o_ready;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StWaitSof;
          err_d   = 1'b0;
          pix_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StWaitSof: begin
        // Beats before the first start-of-frame are swallowed without a write.
        if (accept && i_sof) begin
          do_wr  = 1'b1;
          wr_pix = '0;
          wr_col = '0;
          wr_row = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          do_wr = 1'b1;
          // A fresh start-of-frame mid-load is an error, but the new frame is taken from here.
          if (i_sof) begin
            err_d  = 1'b1;
            wr_pix = '0;
            wr_col = '0;
            wr_row = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (do_wr) begin
      we_d   = 1'b1;
      addr_d = wr_pix;
      data_d = i_data;
      pix_d  = wr_pix + 1'b1;
      if (i_eol != (wr_col == LastCol)) begin
        err_d = 1'b1;
      end
      if (wr_col == LastCol) begin
        col_d = '0;
        row_d = wr_row + 1'b1;
      end else begin
        col_d = wr_col + 1'b1;
        row_d = wr_row;
      end
      if (wr_pix == LastPix) begin
        state_d = StDone;
        num_d   = FrameSize;
      end else begin
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pix_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      num_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      num_q   <= num_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign b0_ce0     = we_q;
  assign b0_we0     = we_q;
  assign b0_addr0   = addr_q;
  assign b0_d0      = data_q;
  assign o_complete = (state_q == StDone);
  assign o_num_cnt  = num_q;
  assign o_err      = err_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_frame_loader_bram0.sv
// Testbench for frame_loader_bram0 with a reduced 7x5 frame. Random beat streams are
// driven through the handshake and every cycle's outputs are compared to a reference
// model built from the frame-loading rules (pixel index, index mod width for lines).
module tb_frame_loader_bram0;

  localparam int W    = 7;
  localparam int H    = 5;
  localparam int SIZE = W * H;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_data;
  logic        i_sof;
  logic        i_eol;
  logic [7:0]  b0_d0;
  logic        b0_ce0;
  logic        b0_we0;
  logic [15:0] b0_addr0;
  logic        o_complete;
  logic [15:0] o_num_cnt;
  logic        o_err;
  logic [1:0]  o_state;

  frame_loader_bram0 #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (16),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_sof     (i_sof),
    .i_eol     (i_eol),
    .b0_d0     (b0_d0),
    .b0_ce0    (b0_ce0),
    .b0_we0    (b0_we0),
    .b0_addr0  (b0_addr0),
    .o_complete(o_complete),
    .o_num_cnt (o_num_cnt),
    .o_err     (o_err),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 waiting for sof, 2 loading, 3 done.
  int          m_mode;
  int          m_idx;
  logic        m_err;
  logic [15:0] m_num;
  logic        m_ce;
  logic [15:0] m_addr;
  logic [7:0]  m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_write(input int a, input logic el, input logic [7:0] d);
    m_ce   = 1'b1;
    m_addr = 16'(a);
    m_data = d;
    if (el != ((a % W) == W - 1)) m_err = 1'b1;
    m_idx = a + 1;
    if (a == SIZE - 1) begin
      m_mode = 3;
      m_num  = 16'(SIZE);
    end else begin
      m_mode = 2;
    end
  endtask

  task automatic model_update(input logic st, input logic v, input logic sf, input logic el,
                              input logic [7:0] d, input logic rn);
    if (!rn) begin
      m_mode = 0;
      m_idx  = 0;
      m_err  = 1'b0;
      m_num  = '0;
      m_ce   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      m_ce = 1'b0;
      case (m_mode)
        0: if (st) begin
          m_mode = 1;
          m_err  = 1'b0;
          m_idx  = 0;
        end
        1: if (v && sf) model_write(0, el, d);
        2: if (v) begin
          if (sf) begin
            m_err = 1'b1;
            model_write(0, el, d);
          end else begin
            model_write(m_idx, el, d);
          end
        end
        3: m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic st, input logic v, input logic sf, input logic el,
                      input logic [7:0] d, input logic rn);
    logic rdy;
    i_start = st;
    i_valid = v;
    i_sof   = sf;
    i_eol   = el;
    i_data  = d;
    rst_n   = rn;
    @(posedge clk);
    model_update(st, v, sf, el, d, rn);
    #1;
    rdy = (m_mode == 1) || (m_mode == 2);
    check("state", 64'(o_state), 64'(m_mode));
    check("wr_port", {b0_ce0, b0_we0, b0_addr0, b0_d0}, {m_ce, m_ce, m_addr, m_data});
    check("status", {(m_mode == 3) ? 1'b1 : 1'b0, rdy, m_err, m_num},
          {o_complete, o_ready, o_err, o_num_cnt});
  endtask

  // Builds a beat stream (junk beats, optional restart, optional bad eol), loads it with
  // random valid gaps, and checks the number of completion pulses seen.
  task automatic run_frame(input int junk, input int bad_eol, input int resof, input int pct,
                           input int rst_at, input int exp_done);
    logic [9:0] q[$];
    logic [9:0] b;
    int cyc;
    int acc;
    int done_cnt;
    logic v;
    logic st;
    logic rn;
    logic will_acc;
    bit   rst_used;
    for (int i = 0; i < junk; i++) q.push_back({1'b0, 1'($urandom), 8'($urandom)});
    if (resof > 0) begin
      for (int i = 0; i < resof; i++)
        q.push_back({(i == 0), ((i % W) == W - 1), 8'($urandom)});
    end
    for (int i = 0; i < SIZE; i++) q.push_back({(i == 0), ((i % W) == W - 1), 8'($urandom)});
    if (bad_eol >= 0) q[junk + bad_eol][8] = ~q[junk + bad_eol][8];

    // Beats offered while idle must be ignored.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    cyc      = 0;
    acc      = 0;
    done_cnt = 0;
    rst_used = 1'b0;
    while ((q.size() > 0 || m_mode != 0) && cyc < 2000) begin
      if (q.size() > 0) v = ($urandom_range(99) < pct);
      else v = (m_mode == 3);
      b  = v && q.size() > 0 ? q[0] : 10'($urandom);
      st = (m_mode != 0) && ($urandom_range(9) == 0);
      rn = !(rst_at >= 0 && !rst_used && acc == rst_at);
      will_acc = v && (m_mode == 1 || m_mode == 2) && q.size() > 0;
      step(st, v, b[9], b[8], b[7:0], rn);
      if (!rn) begin
        rst_used = 1'b1;
        q.delete();
      end else if (will_acc) begin
        void'(q.pop_front());
        acc++;
      end
      if (o_complete) done_cnt++;
      cyc++;
    end
    check("no_timeout", 64'(cyc < 2000), 64'd1);
    check("complete_pulses", 64'(done_cnt), 64'(exp_done));
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_eol   = 1'b0;
    i_data  = '0;

    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hff, 1'b0);
    check("reset_state", {o_state, b0_ce0, b0_addr0, o_num_cnt, o_err}, '0);

    run_frame(0, -1, -1, 100, -1, 1);
    check("num_cnt_full", 64'(o_num_cnt), 64'(SIZE));
    check("err_clean", 64'(o_err), 64'd0);

    run_frame(5, -1, -1, 100, -1, 1);
    check("err_junk", 64'(o_err), 64'd0);

    run_frame(0, 3, -1, 100, -1, 1);
    check("err_bad_eol", 64'(o_err), 64'd1);

    run_frame(0, -1, 20, 100, -1, 1);
    check("err_resof", 64'(o_err), 64'd1);

    run_frame(2, -1, -1, 50, -1, 1);
    check("err_cleared_by_start", 64'(o_err), 64'd0);

    run_frame(0, -1, -1, 100, 17, 0);
    check("reset_mid_state", 64'(o_state), 64'd0);
    check("reset_mid_num", 64'(o_num_cnt), 64'd0);

    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(3), ($urandom_range(1) == 1) ? int'($urandom_range(SIZE - 1)) : -1,
                ($urandom_range(3) == 0) ? 1 + int'($urandom_range(SIZE - 2)) : -1,
                30 + int'($urandom_range(70)), -1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
